// File: rtl/fixed_serializer.sv
// Splits one packed vector of IN_DEPTH signed elements into IN_DEPTH single-element
// beats, sign-extended to OUT_WIDTH, with a bubble-free handover between vectors.
module fixed_serializer #(
  parameter int IN_DEPTH  = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_DEPTH*IN_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [OUT_WIDTH-1:0]         data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         data_out_last
);

  localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DEPTH - 1);

  logic [IN_DEPTH-1:0][IN_WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              full_q, full_d;
  logic signed [IN_WIDTH-1:0]        elem;
  logic                              in_fire, out_fire;

  assign elem           = buf_q[idx_q];
  assign data_out       = OUT_WIDTH'(elem);
  assign data_out_valid = full_q;
  assign data_out_last  = full_q && (idx_q == LAST_IDX);
  // The last-beat term lets the next vector load while the final element leaves.
  assign data_in_ready  = !full_q || (data_out_ready && data_out_last);

  assign in_fire  = data_in_valid && data_in_ready;
  assign out_fire = data_out_valid && data_out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    buf_d  = buf_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (out_fire && !data_out_last) begin
      idx_d = idx_q + IDX_W'(1);
    end else if (out_fire) begin
      idx_d = '0;
      if (in_fire) buf_d  = data_in;
      else         full_d = 1'b0;
    end else if (!full_q && in_fire) begin
      buf_d  = data_in;
      idx_d  = '0;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (rst) begin
      // NOTE: the buffer is cleared too, which is what makes data_out read zero after reset.
      buf_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule
